// File: rtl/multicycle_controller.sv
// Main control FSM for a multicycle RISC-V datapath: sequences fetch, decode,
// memory access, execute and writeback, and flags unsupported opcodes.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state
);

    // state     | meaning
    // ----------+------------------------------------------------
    // FETCH     | read instruction, PC += 4 once memory is ready
    // DECODE    | register read, PC + imm computed for branches
    // MEMADR    | effective address for load/store
    // MEMREAD   | load data read, waits on mem_ready
    // MEMWB     | load data written to register file
    // MEMWRITE  | store in progress, waits on mem_ready
    // EXECUTER  | R-type ALU operation
    // ALUWB     | ALU result written to register file
    // EXECUTEI  | I-type ALU operation
    // JAL       | jump target into PC, return address via ALU
    // BEQ       | compare, branch if Zero
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t     r_state;
    logic       r_illegal;
    logic       r_instr_done;

    state_t     w_next;
    logic       w_retire;
    logic       w_illegal;
    logic [1:0] w_alu_op;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_unused_funct7;

    assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_FETCH;
            r_illegal    <= 1'b0;
            r_instr_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_instr_done <= w_retire;
            if (w_illegal)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next      = S_FETCH;
        w_retire    = 1'b0;
        w_illegal   = 1'b0;
        w_alu_op    = 2'b00;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                w_next     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYP:      w_next = S_EXECUTER;
                    OP_ITYP:      w_next = S_EXECUTEI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                        w_retire  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_MEMWRITE: begin
                // strobe stays up through the whole stall; retire only on ready
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = mem_ready;
                w_next      = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                w_alu_op   = 2'b01;
                w_pc_write = Zero;
                w_retire   = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (w_alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = ({op[5], funct7[5]} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // gate strobes with reset so FETCH's mem_ready-driven writes stay quiet
    assign PCWrite    = w_pc_write  & rst;
    assign IRWrite    = w_ir_write  & rst;
    assign MemWrite   = w_mem_write & rst;
    assign RegWrite   = w_reg_write & rst;
    assign instr_done = r_instr_done;
    assign illegal_op = r_illegal;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its state sequence and checks outputs against hand-derived values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
    logic       instr_done, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; Zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check_val("rst_state", state, 0);
        check_val("rst_irwrite", IRWrite, 0);
        check_val("rst_pcwrite", PCWrite, 0);
        check_val("rst_illegal", illegal_op, 0);
        check_val("rst_done", instr_done, 0);
        check_val("rst_alusrcb", ALUSrcB, 2);
        check_val("rst_resultsrc", ResultSrc, 2);

        // lw, mem_ready high throughout
        rst = 1'b1; op = 7'b0000011;
        #1;
        check_val("lw_f_state", state, 0);
        check_val("lw_f_irwrite", IRWrite, 1);
        check_val("lw_f_pcwrite", PCWrite, 1);
        check_val("lw_f_regwrite", RegWrite, 0);
        step(); #1;
        check_val("lw_d_state", state, 1);
        check_val("lw_d_alusrca", ALUSrcA, 1);
        check_val("lw_d_alusrcb", ALUSrcB, 1);
        check_val("lw_d_aluctl", ALUControl, 0);
        check_val("lw_d_pcwrite", PCWrite, 0);
        check_val("lw_d_regwrite", RegWrite, 0);
        step(); #1;
        check_val("lw_a_state", state, 2);
        check_val("lw_a_alusrca", ALUSrcA, 2);
        check_val("lw_a_regwrite", RegWrite, 0);
        step(); #1;
        check_val("lw_r_state", state, 3);
        check_val("lw_r_adrsrc", AdrSrc, 1);
        check_val("lw_r_regwrite", RegWrite, 0);
        step(); #1;
        check_val("lw_wb_state", state, 4);
        check_val("lw_wb_regwrite", RegWrite, 1);
        check_val("lw_wb_resultsrc", ResultSrc, 1);
        check_val("lw_wb_done", instr_done, 0);
        step();

        // sw with a three-cycle stall in MEMWRITE
        op = 7'b0100011; mem_ready = 1'b1;
        #1;
        check_val("lw_done_pulse", instr_done, 1);
        check_val("sw_f_state", state, 0);
        step();
        mem_ready = 1'b0;
        #1;
        check_val("sw_d_ignore_ready", state, 1);
        check_val("sw_d_done_cleared", instr_done, 0);
        step(); #1;
        check_val("sw_a_state", state, 2);
        check_val("sw_a_immsrc", ImmSrc, 1);
        step();
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            #1;
            check_val("sw_w_state", state, 5);
            check_val("sw_w_memwrite", MemWrite, 1);
            check_val("sw_w_adrsrc", AdrSrc, 1);
            check_val("sw_w_immsrc", ImmSrc, 1);
            check_val("sw_w_done", instr_done, 0);
            step();
        end
        mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000;
        #1;
        check_val("sw_end_state", state, 0);
        check_val("sw_end_memwrite", MemWrite, 0);
        check_val("sw_done_pulse", instr_done, 1);

        // R-type ALU decode exercised while parked in EXECUTER
        step(); step(); #1;
        check_val("r_x_state", state, 6);
        check_val("r_x_alusrca", ALUSrcA, 2);
        check_val("r_x_alusrcb", ALUSrcB, 0);
        check_val("r_sub", ALUControl, 3'b001);
        funct7 = 7'b0000000; #1;
        check_val("r_add", ALUControl, 3'b000);
        funct3 = 3'b111; #1;
        check_val("r_and", ALUControl, 3'b010);
        funct3 = 3'b010; #1;
        check_val("r_slt", ALUControl, 3'b101);
        funct3 = 3'b110; #1;
        check_val("r_or", ALUControl, 3'b011);
        funct3 = 3'b001; #1;
        check_val("r_other", ALUControl, 3'b000);
        step(); #1;
        check_val("r_wb_state", state, 7);
        check_val("r_wb_regwrite", RegWrite, 1);
        step(); #1;
        check_val("r_done_pulse", instr_done, 1);

        // addi with funct7[5]=1 must still add (op[5]=0)
        op = 7'b0010011; funct3 = 3'b000; funct7 = 7'b0100000;
        step(); step(); #1;
        check_val("i_x_state", state, 8);
        check_val("i_x_alusrcb", ALUSrcB, 1);
        check_val("i_addi", ALUControl, 3'b000);
        step(); step();

        // beq: three cycles, PCWrite follows Zero
        op = 7'b1100011; Zero = 1'b1;
        #1;
        check_val("b_f_state", state, 0);
        step(); #1;
        check_val("b_d_immsrc", ImmSrc, 2);
        step(); #1;
        check_val("b_state", state, 10);
        check_val("b_taken_pcwrite", PCWrite, 1);
        check_val("b_aluctl", ALUControl, 3'b001);
        check_val("b_immsrc", ImmSrc, 2);
        Zero = 1'b0; #1;
        check_val("b_nottaken_pcwrite", PCWrite, 0);
        step(); #1;
        check_val("b_end_state", state, 0);
        check_val("b_done_pulse", instr_done, 1);

        // illegal opcode, then jal
        op = 7'b1111111;
        step(); step(); #1;
        check_val("ill_state", state, 0);
        check_val("ill_flag", illegal_op, 1);
        check_val("ill_done_pulse", instr_done, 1);
        op = 7'b1101111;
        step(); #1;
        check_val("j_d_state", state, 1);
        step(); #1;
        check_val("j_state", state, 9);
        check_val("j_pcwrite", PCWrite, 1);
        check_val("j_alusrca", ALUSrcA, 1);
        check_val("j_alusrcb", ALUSrcB, 2);
        check_val("j_immsrc", ImmSrc, 3);
        step(); #1;
        check_val("j_wb_state", state, 7);
        step(); #1;
        check_val("j_end_state", state, 0);
        check_val("ill_sticky", illegal_op, 1);

        // reset aborting a stalled store
        op = 7'b0100011; mem_ready = 1'b1;
        step(); step(); step();
        mem_ready = 1'b0;
        #1;
        check_val("ra_pre_memwrite", MemWrite, 1);
        rst = 1'b0; mem_ready = 1'b1;
        #1;
        check_val("ra_memwrite", MemWrite, 0);
        check_val("ra_state", state, 0);
        check_val("ra_irwrite", IRWrite, 0);
        check_val("ra_illegal", illegal_op, 0);
        step();
        rst = 1'b1;
        #1;
        check_val("ra_rel_irwrite", IRWrite, 1);
        step(); #1;
        check_val("ra_rel_state", state, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
